demorgan_seq: RTL and testbench
===============================

DEMORGAN_SEQ -- requirements
Module: demorgan_seq

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 1, meaning the number of cycles the stimulus is held before sampling (legal 1..15).
REQ-002 SHALL have these ports, in order:
- clk  input  1  single clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request one exhaustive check run.
- seq_a, seq_b  output  1 each  registered stimulus to the gate datapath under test.
- in_nAandnB, in_nPAorBP, in_nAornB, in_nPAandBP  input  1 each  datapath results.
- busy  output  1  run in progress.
- done  output  1  one-cycle pulse at run end.
- pass  output  1  last run had zero mismatches.
- err_count  output  3  number of failing vectors in last run (0..4).
- fail_vec  output  4  bit i set if vector i failed.
REQ-003 SHALL use one clock; reset SHALL be synchronous and active-high, per the fixed decision.

Function
REQ-004 SHALL implement FSM states IDLE, APPLY, SETTLE, CHECK, DONE.
REQ-005 Vector order SHALL be i=0..3 with {seq_a,seq_b} = 00, 01, 10, 11.
REQ-006 IDLE: start=1 SHALL trigger APPLY on the next edge, clear err_count/fail_vec, and set vector index 0.
REQ-007 APPLY (1 cycle): SHALL drive seq_a/seq_b for the current vector, then enter SETTLE.
REQ-008 SETTLE SHALL last exactly SETTLE_CYCLES cycles with stimulus stable, then enter CHECK.
REQ-009 CHECK (1 cycle) SHALL sample the four inputs against golden values:
- nAandnB = nPAorBP = ~(a|b)
- nAornB = nPAandBP = ~(a&b)
REQ-010 Any mismatch in CHECK SHALL set fail_vec[i] and increment err_count (saturating at 4).
REQ-011 After CHECK of vector 3, SHALL enter DONE; otherwise SHALL enter APPLY with the index incremented.
REQ-012 DONE (1 cycle): done=1; pass=(err_count==0); then IDLE.
REQ-013 done SHALL assert exactly 4*(SETTLE_CYCLES+2)+1 cycles after the edge sampling start.
REQ-014 busy SHALL be 1 in APPLY, SETTLE and CHECK, and 0 in IDLE and DONE.
REQ-015 start while busy or in DONE SHALL be ignored (no restart, no queueing).
REQ-016 pass, err_count and fail_vec SHALL hold their values from DONE until the next accepted start.
REQ-017 seq_a/seq_b SHALL hold the last vector after the run and return to 0 only on reset.

Reset
REQ-018 reset SHALL force IDLE, with seq_a=seq_b=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0, and the index and settle counter at 0.
REQ-019 reset asserted mid-run SHALL abort the run with no done pulse; reset SHALL take priority over start in the same cycle.

Configuration
REQ-020 Macro DEMORGAN_SEQ_STOP_ON_FAIL_EN:
- Defined: the first CHECK with a mismatch SHALL go directly to DONE (pass=0, err_count=1, only that fail_vec bit set).
- Undefined: all four vectors SHALL always run.

Structure
REQ-021 Shared package demorgan_pkg SHALL hold the FSM state enum, NUM_VECTORS=4, and the vector index type.
REQ-022 A single sub-module demorgan_golden SHALL be used: combinational; takes a, b and the four sampled results; returns a mismatch bit.

Verification
REQ-023 Correct gate model, SETTLE_CYCLES=1, start pulse -> done 13 cycles later, pass=1, err_count=0, fail_vec=0000.
REQ-024 in_nPAorBP tied 0 -> err_count=1, fail_vec=0001, pass=0 (with macro defined: done 4 cycles after start).
REQ-025 in_nAornB tied 1 -> fail_vec=1000, err_count=1; in_nPAandBP inverted -> fail_vec=1111, err_count=4.
REQ-026 start pulsed again at cycle 5 of a run -> ignored; single done at cycle 13.
REQ-027 reset at cycle 6 of a run -> next cycle all outputs at reset values; no done pulse; a new start runs normally.
REQ-028 SETTLE_CYCLES=3, result inputs change during SETTLE but are correct at CHECK -> pass=1, done at cycle 21.

Source files
------------

// File: rtl/demorgan_pkg.sv
// Shared types for the De Morgan datapath sequencer: FSM states, vector count,
// vector index type and the index-to-stimulus mapping.
package demorgan_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_APPLY  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam int NUM_VECTORS = 4;

    typedef logic [1:0] vec_idx_t;

    // Vector i drives {a,b} = i, so a is the index MSB and b the LSB.
    function automatic logic vec_a(input vec_idx_t idx);
        return idx[1];
    endfunction

    function automatic logic vec_b(input vec_idx_t idx);
        return idx[0];
    endfunction

endpackage

// File: rtl/demorgan_seq_if.sv
// Stimulus/result bundle between the sequencer and the gate datapath under test.
interface demorgan_seq_if;
    logic a;
    logic b;
    logic nAandnB;
    logic nPAorBP;
    logic nAornB;
    logic nPAandBP;

    modport master (output a, output b,
                    input nAandnB, input nPAorBP, input nAornB, input nPAandBP);
    modport slave  (input a, input b,
                    output nAandnB, output nPAorBP, output nAornB, output nPAandBP);
    modport check  (input a, input b,
                    input nAandnB, input nPAorBP, input nAornB, input nPAandBP);
endinterface

// File: rtl/demorgan_golden.sv
// Combinational reference comparison: flags any datapath result that disagrees
// with the De Morgan identities for the applied a/b.
module demorgan_golden (
    demorgan_seq_if.check dp,
    output logic          mismatch
);
    logic w_nor;
    logic w_nand;

    assign w_nor  = ~(dp.a | dp.b);
    assign w_nand = ~(dp.a & dp.b);

    assign mismatch = (dp.nAandnB  != w_nor)  |
                      (dp.nPAorBP  != w_nor)  |
                      (dp.nAornB   != w_nand) |
                      (dp.nPAandBP != w_nand);
endmodule

// File: rtl/demorgan_seq.sv
// Exhaustive 4-vector self-check sequencer for a De Morgan gate datapath.
// Optional build macro DEMORGAN_SEQ_STOP_ON_FAIL_EN ends the run at the first failing vector.
module demorgan_seq
    import demorgan_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       seq_a,
    output logic       seq_b,
    input  logic       in_nAandnB,
    input  logic       in_nPAorBP,
    input  logic       in_nAornB,
    input  logic       in_nPAandBP,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] fail_vec
);
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam vec_idx_t   LAST_IDX    = vec_idx_t'(NUM_VECTORS - 1);
    localparam logic [2:0] ERR_MAX     = 3'(NUM_VECTORS);

    state_t     r_state;
    vec_idx_t   r_idx;
    logic [3:0] r_cnt;
    logic       r_seq_a;
    logic       r_seq_b;
    logic       r_busy;
    logic       r_done;
    logic       r_pass;
    logic [2:0] r_err;
    logic [3:0] r_fail;

    state_t     w_state_nxt;
    vec_idx_t   w_idx_nxt;
    logic [3:0] w_cnt_nxt;
    logic       w_seq_a_nxt;
    logic       w_seq_b_nxt;
    logic       w_pass_nxt;
    logic [2:0] w_err_nxt;
    logic [3:0] w_fail_nxt;
    logic       w_last;
    logic       w_mismatch;

    demorgan_seq_if u_dp_if ();

    assign u_dp_if.a        = r_seq_a;
    assign u_dp_if.b        = r_seq_b;
    assign u_dp_if.nAandnB  = in_nAandnB;
    assign u_dp_if.nPAorBP  = in_nPAorBP;
    assign u_dp_if.nAornB   = in_nAornB;
    assign u_dp_if.nPAandBP = in_nPAandBP;

    demorgan_golden u_golden (
        .dp       (u_dp_if.check),
        .mismatch (w_mismatch)
    );

    // Next-state and next-value logic for the run sequencer.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt;
        w_seq_a_nxt = r_seq_a;
        w_seq_b_nxt = r_seq_b;
        w_pass_nxt  = r_pass;
        w_err_nxt   = r_err;
        w_fail_nxt  = r_fail;
        w_last      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_APPLY;
                    w_idx_nxt   = vec_idx_t'(0);
                    w_seq_a_nxt = vec_a(vec_idx_t'(0));
                    w_seq_b_nxt = vec_b(vec_idx_t'(0));
                    w_pass_nxt  = 1'b0;
                    w_err_nxt   = 3'd0;
                    w_fail_nxt  = 4'd0;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_APPLY: begin
                w_cnt_nxt   = 4'd0;
                w_state_nxt = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (r_cnt == SETTLE_LAST) begin
                    w_state_nxt = ST_CHECK;
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            ST_CHECK: begin
                if (w_mismatch) begin
                    w_fail_nxt[r_idx] = 1'b1;
                    w_err_nxt = (r_err == ERR_MAX) ? ERR_MAX : r_err + 3'd1;
                end else begin
                    w_err_nxt = r_err;
                end
`ifdef DEMORGAN_SEQ_STOP_ON_FAIL_EN
                w_last = (r_idx == LAST_IDX) || w_mismatch;
`else
                w_last = (r_idx == LAST_IDX);
`endif
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                    w_pass_nxt  = (w_err_nxt == 3'd0);
                end else begin
                    w_state_nxt = ST_APPLY;
                    w_idx_nxt   = r_idx + vec_idx_t'(1);
                    w_seq_a_nxt = vec_a(r_idx + vec_idx_t'(1));
                    w_seq_b_nxt = vec_b(r_idx + vec_idx_t'(1));
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and output registers; busy/done are decoded from the next state so they align with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_idx   <= vec_idx_t'(0);
            r_cnt   <= 4'd0;
            r_seq_a <= 1'b0;
            r_seq_b <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_err   <= 3'd0;
            r_fail  <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_cnt   <= w_cnt_nxt;
            r_seq_a <= w_seq_a_nxt;
            r_seq_b <= w_seq_b_nxt;
            r_busy  <= (w_state_nxt == ST_APPLY) || (w_state_nxt == ST_SETTLE) ||
                       (w_state_nxt == ST_CHECK);
            r_done  <= (w_state_nxt == ST_DONE);
            r_pass  <= w_pass_nxt;
            r_err   <= w_err_nxt;
            r_fail  <= w_fail_nxt;
        end
    end

    assign seq_a     = r_seq_a;
    assign seq_b     = r_seq_b;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign err_count = r_err;
    assign fail_vec  = r_fail;

endmodule

// File: tb/tb_demorgan_seq.sv
// Bench for demorgan_seq: behavioural gate datapath with injectable faults,
// table-driven fault runs, randomized corruption runs and timing corner cases.
module tb_demorgan_seq;

    typedef struct {
        string      name;
        int         mode;
        logic [3:0] exp_fv;
        logic [2:0] exp_err;
        logic       exp_pass;
        int         exp_lat;
    } vec_t;

    logic clk;
    logic reset;
    logic start1;
    logic start3;
    logic busy1, done1, pass1;
    logic busy3, done3, pass3;
    logic [2:0] err1, err3;
    logic [3:0] fv1, fv3;

    int n_tests;
    int n_fail;
    int mode1;
    int t3;
    logic [3:0] corrupt [4];
    logic [3:0] dp1;
    logic [3:0] dp3;

    demorgan_seq_if if1 ();
    demorgan_seq_if if3 ();

    demorgan_seq #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1),
        .seq_a(if1.a), .seq_b(if1.b),
        .in_nAandnB(if1.nAandnB), .in_nPAorBP(if1.nPAorBP),
        .in_nAornB(if1.nAornB), .in_nPAandBP(if1.nPAandBP),
        .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .fail_vec(fv1)
    );

    demorgan_seq #(.SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .reset(reset), .start(start3),
        .seq_a(if3.a), .seq_b(if3.b),
        .in_nAandnB(if3.nAandnB), .in_nPAorBP(if3.nPAorBP),
        .in_nAornB(if3.nAornB), .in_nPAandBP(if3.nPAandBP),
        .busy(busy3), .done(done3), .pass(pass3),
        .err_count(err3), .fail_vec(fv3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Ideal results {nAandnB, nPAorBP, nAornB, nPAandBP} from plain arithmetic on a and b.
    function automatic logic [3:0] golden4(input logic a, input logic b);
        int s;
        int p;
        logic nor_v;
        logic nand_v;
        s = int'(a) + int'(b);
        p = int'(a) * int'(b);
        nor_v  = (s == 0);
        nand_v = (p == 0);
        return {nor_v, nor_v, nand_v, nand_v};
    endfunction

    // Datapath model for the SETTLE_CYCLES=1 instance with selectable faults.
    always_comb begin
        dp1 = golden4(if1.a, if1.b);
        case (mode1)
            1:       dp1[2] = 1'b0;
            2:       dp1[1] = 1'b1;
            3:       dp1[0] = ~dp1[0];
            default: dp1 = dp1 ^ corrupt[{if1.a, if1.b}];
        endcase
    end
    assign if1.nAandnB  = dp1[3];
    assign if1.nPAorBP  = dp1[2];
    assign if1.nAornB   = dp1[1];
    assign if1.nPAandBP = dp1[0];

    // SETTLE_CYCLES=3 datapath: wrong in every cycle except the 5th of each vector slot.
    always_comb begin
        dp3 = golden4(if3.a, if3.b);
        if (((t3 - 1) % 5) != 4) dp3 = ~dp3;
    end
    assign if3.nAandnB  = dp3[3];
    assign if3.nPAorBP  = dp3[2];
    assign if3.nAornB   = dp3[1];
    assign if3.nPAandBP = dp3[0];

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_seq"}, int'({if1.a, if1.b}), 0);
        chk({nm, "_busy"}, int'(busy1), 0);
        chk({nm, "_done"}, int'(done1), 0);
        chk({nm, "_pass"}, int'(pass1), 0);
        chk({nm, "_err"}, int'(err1), 0);
        chk({nm, "_fv"}, int'(fv1), 0);
    endtask

    // One run on the SETTLE_CYCLES=1 instance; an optional extra start pulse at cycle 'extra'.
    task automatic run1(input string nm, input logic [3:0] efv, input logic [2:0] eerr,
                        input logic epass, input int elat, input int extra);
        int lat;
        int ndone;
        int lastv;
        lat = -1;
        ndone = 0;
        lastv = 3;
`ifdef DEMORGAN_SEQ_STOP_ON_FAIL_EN
        for (int i = 3; i >= 0; i--) if (efv[i]) lastv = i;
`endif
        start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            start1 = (c == extra);
            if (c == 1) chk({nm, "_busy_c1"}, int'(busy1), 1);
            if (done1) begin
                ndone++;
                if (lat < 0) begin
                    lat = c;
                    chk({nm, "_busy_at_done"}, int'(busy1), 0);
                end
            end
        end
        start1 = 1'b0;
        chk({nm, "_latency"}, lat, elat);
        chk({nm, "_ndone"}, ndone, 1);
        chk({nm, "_fail_vec"}, int'(fv1), int'(efv));
        chk({nm, "_err_count"}, int'(err1), int'(eerr));
        chk({nm, "_pass"}, int'(pass1), int'(epass));
        chk({nm, "_seq_hold"}, int'({if1.a, if1.b}), lastv);
    endtask

    vec_t tbl [4];

    initial begin
        n_tests = 0;
        n_fail  = 0;
        mode1   = 0;
        t3      = 0;
        reset   = 1'b1;
        start1  = 1'b0;
        start3  = 1'b0;
        for (int i = 0; i < 4; i++) corrupt[i] = 4'd0;

        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        chk("reset_busy3", int'(busy3), 0);
        reset = 1'b0;
        @(negedge clk);

        tbl[0] = '{"correct", 0, 4'b0000, 3'd0, 1'b1, 13};
`ifdef DEMORGAN_SEQ_STOP_ON_FAIL_EN
        tbl[1] = '{"nPAorBP_tied0", 1, 4'b0001, 3'd1, 1'b0, 4};
        tbl[2] = '{"nAornB_tied1",  2, 4'b1000, 3'd1, 1'b0, 13};
        tbl[3] = '{"nPAandBP_inv",  3, 4'b0001, 3'd1, 1'b0, 4};
`else
        tbl[1] = '{"nPAorBP_tied0", 1, 4'b0001, 3'd1, 1'b0, 13};
        tbl[2] = '{"nAornB_tied1",  2, 4'b1000, 3'd1, 1'b0, 13};
        tbl[3] = '{"nPAandBP_inv",  3, 4'b1111, 3'd4, 1'b0, 13};
`endif
        for (int k = 0; k < 4; k++) begin
            mode1 = tbl[k].mode;
            run1(tbl[k].name, tbl[k].exp_fv, tbl[k].exp_err, tbl[k].exp_pass, tbl[k].exp_lat, 0);
        end

        // Second start mid-run must be ignored.
        mode1 = 0;
        run1("restart_ignored", 4'b0000, 3'd0, 1'b1, 13, 5);

        // Randomized corruption against the reference model.
        for (int r = 0; r < 8; r++) begin
            logic [3:0] efv;
            logic [2:0] eerr;
            int elat;
            int first;
            efv = 4'd0;
            eerr = 3'd0;
            first = -1;
            for (int i = 0; i < 4; i++) begin
                corrupt[i] = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
                if (corrupt[i] != 4'd0) begin
                    efv[i] = 1'b1;
                    eerr = eerr + 3'd1;
                    if (first < 0) first = i;
                end
            end
            elat = 13;
`ifdef DEMORGAN_SEQ_STOP_ON_FAIL_EN
            if (first >= 0) begin
                efv = 4'd0;
                efv[first] = 1'b1;
                eerr = 3'd1;
                elat = (first + 1) * 3 + 1;
            end
`endif
            run1($sformatf("rand%0d", r), efv, eerr, (eerr == 3'd0), elat, 0);
        end
        for (int i = 0; i < 4; i++) corrupt[i] = 4'd0;

        // Reset and start in the same cycle: reset wins.
        reset = 1'b1;
        start1 = 1'b1;
        @(negedge clk);
        chk("rst_prio_busy", int'(busy1), 0);
        reset = 1'b0;
        start1 = 1'b0;
        @(negedge clk);

        // Reset at cycle 6 of a failing run aborts it.
        begin
            int ndone;
            ndone = 0;
            mode1 = 1;
            start1 = 1'b1;
            @(posedge clk);
            #1 start1 = 1'b0;
            for (int c = 1; c <= 6; c++) @(negedge clk);
            reset = 1'b1;
            @(negedge clk);
            chk_reset_vals("mid_reset");
            reset = 1'b0;
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                if (done1) ndone++;
            end
            chk("mid_reset_no_done", ndone, 0);
        end
        mode1 = 0;
        run1("after_reset", 4'b0000, 3'd0, 1'b1, 13, 0);

        // SETTLE_CYCLES=3 with results wrong everywhere except at CHECK.
        begin
            int lat;
            lat = -1;
            start3 = 1'b1;
            @(posedge clk);
            #1 start3 = 1'b0;
            for (int c = 1; c <= 40; c++) begin
                @(negedge clk);
                t3 = c;
                if (done3 && lat < 0) lat = c;
            end
            t3 = 0;
            chk("settle3_latency", lat, 21);
            chk("settle3_pass", int'(pass3), 1);
            chk("settle3_err", int'(err3), 0);
            chk("settle3_fv", int'(fv3), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
